ether_rx_ctrl: RTL

Frame-level receive controller behind the RMII dibit receiver. It packs the receiver's dibit stream into bytes and filters frames on destination MAC. It enforces length and alignment rules and sequences accepted frames to the downstream byte consumer with start/done/status markers. Rejected frames are dropped and counted. Flow is push-only: the RMII stream cannot stall, so there is no ready input.

---
 rtl/ether_rx_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/ether_rx_ctrl.sv
// ether_rx_ctrl: frame-level RMII receive controller. Packs dibits into bytes,
// filters on destination MAC, checks length/alignment and delivers frames.
// Ports: clk, rst (sync, active high); axiiv/axiid dibit stream from the
// receiver; enable arms reception in IDLE; byte_valid/byte_data/frame_start
// byte stream; frame_done/frame_ok/frame_len end-of-frame status;
// drop_count saturating count of rejected frames.
module ether_rx_ctrl #(
    parameter logic [47:0] MAC_ADDR  = 48'h02_00_00_00_00_01,
    parameter bit          PROMISC   = 1'b0,
    parameter int          MIN_BYTES = 64,
    parameter int          MAX_BYTES = 1518
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        axiiv,
    input  logic [1:0]  axiid,
    input  logic        enable,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    output logic        frame_start,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [10:0] frame_len,
    output logic [15:0] drop_count
);
    localparam logic [10:0] MIN_L = 11'(MIN_BYTES);
    localparam logic [10:0] MAX_L = 11'(MAX_BYTES);

    typedef enum logic [2:0] {SKIP, IDLE, HEADER, PASS, FLUSH} state_t;
    state_t state, state_nxt;

    logic [7:0]  sh;
    logic [1:0]  dcnt;
    logic [10:0] bcnt;
    logic [7:0]  line [6];
    logic [2:0]  fcnt;
    logic        started;
    logic        aligned;
    logic        busy;

    logic        sampling;
    logic        comp;
    logic        match;
    logic        oversize;
    logic [7:0]  new_byte;
    logic [47:0] addr;

    logic        bv_d;
    logic [7:0]  bd_d;
    logic        fs_d;
    logic        fd_d;
    logic        ok_d;
    logic [10:0] len_d;
    logic        drop_d;

    assign sampling = axiiv && (state == HEADER || state == PASS);
    assign comp     = sampling && dcnt == 2'd3;
    assign new_byte = {axiid, sh[7:2]};
    // line[0] is the newest byte; the completing byte is the 6th address byte
    assign addr     = {line[4], line[3], line[2], line[1], line[0], new_byte};
    assign match    = PROMISC || addr == MAC_ADDR || addr == '1;
    // bcnt holds bytes completed so far, so this completion is byte MAX+1
    assign oversize = state == PASS && comp && bcnt == MAX_L;

    always_ff @(posedge clk) begin
        if (rst) state <= SKIP;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            SKIP:   if (!axiiv) state_nxt = IDLE;
            IDLE:   if (axiiv) state_nxt = enable ? HEADER : SKIP;
            HEADER: begin
                if (!axiiv)
                    state_nxt = IDLE;
                else if (comp && bcnt == 11'd5)
                    state_nxt = match ? PASS : SKIP;
            end
            PASS: begin
                if (!axiiv)        state_nxt = FLUSH;
                else if (oversize) state_nxt = SKIP;
            end
            FLUSH:  if (fcnt == 3'd5) state_nxt = (busy || axiiv) ? SKIP : IDLE;
            default: state_nxt = SKIP;
        endcase
    end

    always_comb begin
        bv_d   = 1'b0;
        bd_d   = 8'h00;
        fs_d   = 1'b0;
        fd_d   = 1'b0;
        ok_d   = 1'b0;
        len_d  = bcnt;
        drop_d = 1'b0;
        unique case (state)
            HEADER: begin
                if (!axiiv || (comp && bcnt == 11'd5 && !match))
                    drop_d = 1'b1;
            end
            PASS: begin
                if (oversize) begin
                    fd_d   = 1'b1;
                    len_d  = bcnt + 11'd1;
                    drop_d = 1'b1;
                end else if (comp) begin
                    bv_d = 1'b1;
                    bd_d = line[5];
                    fs_d = !started;
                end
            end
            FLUSH: begin
                bv_d = 1'b1;
                bd_d = line[5];
                fs_d = !started;
                if (fcnt == 3'd5) begin
                    fd_d   = 1'b1;
                    ok_d   = aligned && bcnt >= MIN_L && bcnt <= MAX_L;
                    drop_d = !ok_d;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_valid  <= 1'b0;
            byte_data   <= 8'h00;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_ok    <= 1'b0;
            frame_len   <= 11'd0;
            drop_count  <= 16'd0;
        end else begin
            byte_valid  <= bv_d;
            byte_data   <= bd_d;
            frame_start <= fs_d;
            frame_done  <= fd_d;
            if (fd_d) begin
                frame_ok  <= ok_d;
                frame_len <= len_d;
            end
            if (drop_d && drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh      <= 8'h00;
            dcnt    <= 2'd0;
            bcnt    <= 11'd0;
            fcnt    <= 3'd0;
            started <= 1'b0;
            aligned <= 1'b0;
            busy    <= 1'b0;
            for (int i = 0; i < 6; i++) line[i] <= 8'h00;
        end else begin
            // the dibit seen on IDLE exit is dibit 0 of the frame
            if (state == IDLE) begin
                bcnt <= 11'd0;
                if (axiiv && enable) begin
                    sh   <= new_byte;
                    dcnt <= 2'd1;
                end else begin
                    dcnt <= 2'd0;
                end
            end else if (sampling) begin
                sh   <= new_byte;
                dcnt <= dcnt + 2'd1;
                if (comp) begin
                    bcnt <= bcnt + 11'd1;
                    for (int i = 5; i > 0; i--) line[i] <= line[i-1];
                    line[0] <= new_byte;
                end
            end else begin
                dcnt <= 2'd0;
                if (state == FLUSH) begin
                    for (int i = 5; i > 0; i--) line[i] <= line[i-1];
                    line[0] <= 8'h00;
                end
            end
            started <= (state == IDLE) ? 1'b0 : (started | bv_d);
            // dcnt is 0 here only if the last dibit closed a whole byte
            if (state == PASS && !axiiv)
                aligned <= dcnt == 2'd0;
            fcnt <= (state == FLUSH) ? fcnt + 3'd1 : 3'd0;
            busy <= (state == FLUSH) ? (busy | axiiv) : 1'b0;
        end
    end
endmodule
